// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared types and encodings for the multicycle ARM controller.
// Rev 1.0
`default_nettype none

package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    ok = 1'b0;
    case (cond)
      CC_EQ: ok = z;
      CC_NE: ok = ~z;
      CC_CS: ok = c;
      CC_CC: ok = ~c;
      CC_MI: ok = n;
      CC_PL: ok = ~n;
      CC_VS: ok = v;
      CC_VC: ok = ~v;
      CC_HI: ok = c & ~z;
      CC_LS: ok = ~c | z;
      CC_GE: ok = (n == v);
      CC_LT: ok = (n != v);
      CC_GT: ok = ~z & (n == v);
      CC_LE: ok = z | (n != v);
      CC_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arm_mc_condlogic.sv
// arm_mc_condlogic: NZCV flag register, condition evaluation and latched CondExR.
// Rev 1.0
`default_nettype none

module arm_mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       cond_ex_w,
  output logic       CondExR
);

  logic [3:0] flags;
  logic       cond_ex;

  assign cond_ex = cond_eval(Cond, flags);

  // FlagW[1] covers N,Z; FlagW[0] covers C,V
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags   <= 4'b0000;
      CondExR <= 1'b0;
    end else begin
      if (FlagW[1] && CondExR) flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && CondExR) flags[1:0] <= ALUFlags[1:0];
      if (cond_ex_w) CondExR <= cond_ex;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control FSM; ARM_MC_PERF_EN adds cycle/instruction counters.
// Rev 1.0
`default_nettype none

module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int ALUC_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [CNT_W-1:0]  CycleCount,
  output logic [CNT_W-1:0]  InstrCount
);

  state_t     state, next_state, dec_state;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cmd;
  logic [2:0] dp_alu;
  logic       dp_valid, no_write, cv_upd;
  logic       irw, pcw_f, regw, memw, branch, alu_dp, flag_en, cond_ex_w;
  logic       cond_ex_r, reg_ok;
  logic [1:0] flag_w;
  logic       unused_instr_bits;

  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd    = Instr[7:4];
  assign cmd   = funct[4:1];
  assign unused_instr_bits = ^Instr[3:0];

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_valid = 1'b1;
    no_write = 1'b0;
    cv_upd   = 1'b0;
    case (cmd)
      CMD_ADD: begin dp_alu = ALU_ADD; cv_upd = 1'b1; end
      CMD_SUB: begin dp_alu = ALU_SUB; cv_upd = 1'b1; end
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_EOR: if (ALUC_W >= 3) dp_alu = ALU_EOR; else dp_valid = 1'b0;
      CMD_CMP: if (ALUC_W >= 3) begin dp_alu = ALU_SUB; no_write = 1'b1; cv_upd = 1'b1; end
               else dp_valid = 1'b0;
      CMD_TST: if (ALUC_W >= 3) begin dp_alu = ALU_AND; no_write = 1'b1; end
               else dp_valid = 1'b0;
      CMD_MOV: if (ALUC_W >= 3) dp_alu = ALU_MOV; else dp_valid = 1'b0;
      default: dp_valid = 1'b0;
    endcase
    if (!dp_valid) begin
      dp_alu   = ALU_ADD;
      no_write = 1'b1;
      cv_upd   = 1'b0;
    end
    // Funct[4:1] only names an ALU command for data-processing instructions
    if (op != OP_DP) no_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Held in reset, the datapath selects show the FETCH decode
  assign dec_state = reset ? state : S_FETCH;

  always_comb begin
    next_state = S_FETCH;
    irw = 1'b0; pcw_f = 1'b0; regw = 1'b0; memw = 1'b0; branch = 1'b0;
    alu_dp = 1'b0; flag_en = 1'b0; cond_ex_w = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ResultSrc = 2'b00;
    case (dec_state)
      S_FETCH: begin
        next_state = S_DECODE;
        irw = 1'b1; pcw_f = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        cond_ex_w = 1'b1;
        case (op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        next_state = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD:  begin AdrSrc = 1'b1; next_state = S_MEMWB; end
      S_MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
      S_EXECR:  begin alu_dp = 1'b1; flag_en = 1'b1; next_state = S_ALUWB; end
      S_EXECI:  begin ALUSrcB = 2'b01; alu_dp = 1'b1; flag_en = 1'b1; next_state = S_ALUWB; end
      S_ALUWB:  regw = 1'b1;
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default:  next_state = S_FETCH;
    endcase
  end

  assign flag_w = {flag_en & funct[0] & dp_valid, flag_en & funct[0] & dp_valid & cv_upd};

  arm_mc_condlogic u_condlogic (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Instr[19:16]),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .cond_ex_w(cond_ex_w),
    .CondExR  (cond_ex_r)
  );

  assign reg_ok     = regw & cond_ex_r & ~no_write;
  assign IRWrite    = irw & reset;
  assign MemWrite   = memw & cond_ex_r & reset;
  assign RegWrite   = reg_ok & reset;
  assign PCWrite    = reset & (pcw_f | (branch & cond_ex_r) | ((rd == 4'hF) & reg_ok));
  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ALUControl = alu_dp ? ALUC_W'(dp_alu) : '0;

`ifdef ARM_MC_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  logic             retire;

  assign retire = (state != S_FETCH) && (next_state == S_FETCH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign CycleCount = cycle_cnt;
  assign InstrCount = instr_cnt;
`else
  assign CycleCount = '0;
  assign InstrCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: directed vector bench for arm_mc_controller (ALUC_W=3 and ALUC_W=2 side by side).
// Rev 1.0
`default_nettype none

module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = 20'hE2821;
  logic [3:0]  ALUFlags = 4'b0000;

  logic        pcw3, mw3, rw3, irw3, adr3, sa3;
  logic [1:0]  sb3, rs3, is3, rg3;
  logic [2:0]  alu3;
  logic [31:0] cyc3, ic3;
  logic        pcw2, mw2, rw2, irw2, adr2, sa2;
  logic [1:0]  sb2, rs2, is2, rg2;
  logic [1:0]  alu2;
  logic [31:0] cyc2, ic2;

  arm_mc_controller #(.ALUC_W(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw3), .MemWrite(mw3), .RegWrite(rw3), .IRWrite(irw3), .AdrSrc(adr3), .ALUSrcA(sa3),
    .ALUSrcB(sb3), .ResultSrc(rs3), .ImmSrc(is3), .RegSrc(rg3), .ALUControl(alu3),
    .CycleCount(cyc3), .InstrCount(ic3)
  );

  arm_mc_controller #(.ALUC_W(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw2), .MemWrite(mw2), .RegWrite(rw2), .IRWrite(irw2), .AdrSrc(adr2), .ALUSrcA(sa2),
    .ALUSrcB(sb2), .ResultSrc(rs2), .ImmSrc(is2), .RegSrc(rg2), .ALUControl(alu2),
    .CycleCount(cyc2), .InstrCount(ic2)
  );

  always #5 clk = ~clk;

  logic [16:0] w3;
  assign w3 = {pcw3, mw3, rw3, irw3, adr3, sa3, sb3, rs3, is3, rg3, alu3};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string            name;
    logic [19:0]      instr;
    logic [3:0]       flags;
    int               len;
    logic [4:0][16:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  function automatic logic [16:0] pk(input logic pcw, input logic mw, input logic rw, input logic irw,
                                     input logic adr, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [1:0] is, input logic [1:0] rg,
                                     input logic [2:0] alu);
    return {pcw, mw, rw, irw, adr, sa, sb, rs, is, rg, alu};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input string name, input logic [19:0] instr, input logic [3:0] flags,
                         input int len, input logic [16:0] e0, input logic [16:0] e1, input logic [16:0] e2,
                         input logic [16:0] e3, input logic [16:0] e4);
    tbl[idx].name  = name;
    tbl[idx].instr = instr;
    tbl[idx].flags = flags;
    tbl[idx].len   = len;
    tbl[idx].exp   = {e4, e3, e2, e1, e0};
  endtask

  // Runs one instruction from FETCH, comparing the ALUC_W=3 outputs each cycle
  task automatic run_vec(input int v);
    Instr    = tbl[v].instr;
    ALUFlags = tbl[v].flags;
    for (int c = 0; c < tbl[v].len; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tbl[v].name, c), 32'(w3), 32'(tbl[v].exp[c]));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] f_dp, d_dp, f_br, d_br, f_mem, d_mem, wb_rw, z17;
    logic [31:0] exp_cyc, exp_ic;

    f_dp  = pk(1,0,0,1,0,1,2'b10,2'b10,2'b00,2'b00,3'd0);
    d_dp  = pk(0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,3'd0);
    f_br  = pk(1,0,0,1,0,1,2'b10,2'b10,2'b10,2'b01,3'd0);
    d_br  = pk(0,0,0,0,0,1,2'b10,2'b10,2'b10,2'b01,3'd0);
    f_mem = pk(1,0,0,1,0,1,2'b10,2'b10,2'b01,2'b10,3'd0);
    d_mem = pk(0,0,0,0,0,1,2'b10,2'b10,2'b01,2'b10,3'd0);
    wb_rw = pk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'd0);
    z17   = 17'd0;

    set_vec(0, "add_imm", 20'hE2821, 4'b0000, 4, f_dp, d_dp,
            pk(0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'd0), wb_rw, z17);
    set_vec(1, "subs_z", 20'hE0511, 4'b0100, 4, f_dp, d_dp,
            pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'd1), wb_rw, z17);
    set_vec(2, "beq_taken", 20'h0A000, 4'b0000, 3, f_br, d_br,
            pk(1,0,0,0,0,0,2'b01,2'b10,2'b10,2'b01,3'd0), z17, z17);
    set_vec(3, "subs_nz", 20'hE0511, 4'b0000, 4, f_dp, d_dp,
            pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'd1), wb_rw, z17);
    set_vec(4, "beq_not", 20'h0A000, 4'b0000, 3, f_br, d_br,
            pk(0,0,0,0,0,0,2'b01,2'b10,2'b10,2'b01,3'd0), z17, z17);
    set_vec(5, "ldr", 20'hE5921, 4'b0000, 5, f_mem, d_mem,
            pk(0,0,0,0,0,0,2'b01,2'b00,2'b01,2'b10,3'd0),
            pk(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b10,3'd0),
            pk(0,0,1,0,0,0,2'b00,2'b01,2'b01,2'b10,3'd0));
    set_vec(6, "str", 20'hE5821, 4'b0000, 4, f_mem, d_mem,
            pk(0,0,0,0,0,0,2'b01,2'b00,2'b01,2'b10,3'd0),
            pk(0,1,0,0,1,0,2'b00,2'b00,2'b01,2'b10,3'd0), z17);
    set_vec(7, "add_pc", 20'hE28FF, 4'b0000, 4, f_dp, d_dp,
            pk(0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'd0),
            pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'd0), z17);
    set_vec(8, "undef", 20'hEC000, 4'b0000, 2,
            pk(1,0,0,1,0,1,2'b10,2'b10,2'b11,2'b00,3'd0),
            pk(0,0,0,0,0,1,2'b10,2'b10,2'b11,2'b00,3'd0), z17, z17, z17);
    set_vec(9, "adds_nv", 20'hF2921, 4'b1111, 4, f_dp, d_dp,
            pk(0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'd0), z17, z17);

    // Reset held low for three edges; strobes must stay quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_out_%0d", i), 32'(w3), 32'(d_dp));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("flags_after_reset", 32'(dut3.u_condlogic.flags), 32'h0);
    check("cycle_after_reset", cyc3, 32'd0);
    check("instr_after_reset", ic3, 32'd0);

    for (int v = 0; v < NV; v++) run_vec(v);

    check("flags3_after_table", 32'(dut3.u_condlogic.flags), 32'h0);
    check("flags2_after_table", 32'(dut2.u_condlogic.flags), 32'h0);

    // CMP: extended op on ALUC_W=3, unsupported on ALUC_W=2
    Instr = 20'hE1510; ALUFlags = 4'b1011;
    tick(); tick();
    @(negedge clk);
    check("cmp_alu3", 32'(alu3), 32'd1);
    check("cmp_alu2", 32'(alu2), 32'd0);
    tick();
    @(negedge clk);
    check("cmp_rw3", 32'(rw3), 32'd0);
    check("cmp_rw2", 32'(rw2), 32'd0);
    tick();
    check("cmp_flags3", 32'(dut3.u_condlogic.flags), 32'hB);
    check("cmp_flags2", 32'(dut2.u_condlogic.flags), 32'h0);

    // ANDS: N,Z written, C,V kept
    Instr = 20'hE0121; ALUFlags = 4'b0100;
    tick(); tick();
    @(negedge clk);
    check("ands_alu3", 32'(alu3), 32'd2);
    check("ands_alu2", 32'(alu2), 32'd2);
    tick();
    @(negedge clk);
    check("ands_rw3", 32'(rw3), 32'd1);
    check("ands_rw2", 32'(rw2), 32'd1);
    tick();
    check("ands_flags3", 32'(dut3.u_condlogic.flags), 32'h7);
    check("ands_flags2", 32'(dut2.u_condlogic.flags), 32'h4);

    // MOV immediate
    Instr = 20'hE3A10; ALUFlags = 4'b0000;
    tick(); tick();
    @(negedge clk);
    check("mov_alu3", 32'(alu3), 32'd5);
    check("mov_alu2", 32'(alu2), 32'd0);
    tick();
    @(negedge clk);
    check("mov_rw3", 32'(rw3), 32'd1);
    check("mov_rw2", 32'(rw2), 32'd0);
    tick();

    // Counters: fresh reset, three ADDs, then reset mid-EXECI
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) run_vec(0);
`ifdef ARM_MC_PERF_EN
    exp_cyc = 32'd12; exp_ic = 32'd3;
`else
    exp_cyc = 32'd0;  exp_ic = 32'd0;
`endif
    @(negedge clk);
    check("perf_cycles", cyc3, exp_cyc);
    check("perf_instrs", ic3, exp_ic);
    check("perf_fetch", 32'(w3), 32'(f_dp));
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("midexec_reset_out", 32'(w3), 32'(d_dp));
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midexec_refetch", 32'(w3), 32'(f_dp));
    check("midexec_cycles", cyc3, 32'd0);
    check("midexec_instrs", ic3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
